// File: rtl/soc_bram_pkg.sv
// ----------------------------------------------------------------------------
// soc_bram_pkg
// Shared types and default sizes for the program-BRAM access arbiter.
//   arb_state_t : one-hot arbiter FSM state encoding
//   gnt_t       : identifies which requester was granted most recently
// ----------------------------------------------------------------------------
package soc_bram_pkg;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_LAT = 2;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_WR       = 5'b00010,
        ST_RD_ISSUE = 5'b00100,
        ST_RD_WAIT  = 5'b01000,
        ST_RD_DONE  = 5'b10000
    } arb_state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// ----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin pick, purely combinational. The last-grant register is
// owned by the parent so the pick only advances when the parent commits it.
// Ports:
//   req        in  [1:0]  request vector, [0] = write path, [1] = read path
//   last_grant in  gnt_t  requester granted most recently
//   grant      out [1:0]  one-hot grant (all zero when nothing requested)
// ----------------------------------------------------------------------------
module rr_arbiter_2
    import soc_bram_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_t       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // Under contention the requester that did not win last time goes first.
        if (req == 2'b11) begin
            grant = (last_grant == GNT_RD) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/bram_access_arbiter.sv
// ----------------------------------------------------------------------------
// bram_access_arbiter
// Shares one single-port program BRAM between the programming (write) path and
// the display/load (read) path. One access is in flight at a time; reads wait
// out the fixed BRAM latency and return registered data with a valid strobe.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no access; sample requests and capture the winner
// ST_WR       | write issued to BRAM (one cycle)
// ST_RD_ISSUE | read issued to BRAM (one cycle), latency counter loaded
// ST_RD_WAIT  | waiting for BRAM read latency to elapse
// ST_RD_DONE  | bram_dout valid this cycle; registered into rd_data
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data/wr_gnt  write requester handshake
//   rd_req/rd_addr/rd_gnt          read requester handshake
//   rd_data/rd_valid               registered read return
//   bram_en/we/addr/din/dout       BRAM port
//   busy                           high whenever not in ST_IDLE
// ----------------------------------------------------------------------------
module bram_access_arbiter
    import soc_bram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              busy
);

    // Counter runs in ST_RD_WAIT and hands over to ST_RD_DONE at 1, so it is
    // loaded with RD_LAT-1 (the ST_RD_ISSUE cycle already counts as one).
    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    gnt_t              last_grant;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic [2:0]        lat_cnt;

    rr_arbiter_2 u_rr (
        .req        ({rd_req, wr_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (grant[0]) begin
                    state_nxt = ST_WR;
                end else if (grant[1]) begin
                    state_nxt = ST_RD_ISSUE;
                end
            end
            ST_WR:       state_nxt = ST_IDLE;
            ST_RD_ISSUE: state_nxt = (RD_LAT == 1) ? ST_RD_DONE : ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (lat_cnt == 3'd1) begin
                    state_nxt = ST_RD_DONE;
                end
            end
            ST_RD_DONE:  state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= GNT_RD;
            cap_addr   <= '0;
            cap_data   <= '0;
            lat_cnt    <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_valid <= (state == ST_RD_DONE);

            if (state == ST_RD_DONE) begin
                rd_data <= bram_dout;
            end

            if (state == ST_IDLE) begin
                if (grant[0]) begin
                    cap_addr   <= wr_addr;
                    cap_data   <= wr_data;
                    last_grant <= GNT_WR;
                end else if (grant[1]) begin
                    cap_addr   <= rd_addr;
                    last_grant <= GNT_RD;
                end
            end

            if (state == ST_RD_ISSUE) begin
                lat_cnt <= LAT_INIT;
            end else if (state == ST_RD_WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
        end
    end

    // Port outputs decode straight from state; address and data are forced to
    // zero outside the issue cycles so an idle BRAM port is fully quiet.
    assign wr_gnt    = (state == ST_WR);
    assign rd_gnt    = (state == ST_RD_ISSUE);
    assign bram_en   = wr_gnt | rd_gnt;
    assign bram_we   = wr_gnt;
    assign bram_addr = bram_en ? cap_addr : '0;
    assign bram_din  = wr_gnt ? cap_data : '0;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_bram_access_arbiter.sv
`timescale 1ns/1ps
module tb_bram_access_arbiter;

    localparam int AW  = 2;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int NV  = 26;

    localparam logic [DW-1:0] D0   = 32'hdeadbeef;
    localparam logic [DW-1:0] D1   = 32'ha5a50000;
    localparam logic [DW-1:0] D2   = 32'h00001111;
    localparam logic [DW-1:0] D3   = 32'h12345678;
    localparam logic [DW-1:0] JUNK = 32'hbadc0de5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // main instance, RD_LAT = 2
    logic          wr_req, rd_req, wr_gnt, rd_gnt, rd_valid, bram_en, bram_we, busy;
    logic [AW-1:0] wr_addr, rd_addr, bram_addr;
    logic [DW-1:0] wr_data, rd_data, bram_din, bram_dout;

    // second instance, RD_LAT = 1
    logic          wr_req1, rd_req1, wr_gnt1, rd_gnt1, rd_valid1, bram_en1, bram_we1, busy1;
    logic [AW-1:0] wr_addr1, rd_addr1, bram_addr1;
    logic [DW-1:0] wr_data1, rd_data1, bram_din1, bram_dout1;

    bram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout), .busy(busy)
    );

    bram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_gnt(wr_gnt1),
        .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_gnt(rd_gnt1),
        .rd_data(rd_data1), .rd_valid(rd_valid1),
        .bram_en(bram_en1), .bram_we(bram_we1), .bram_addr(bram_addr1),
        .bram_din(bram_din1), .bram_dout(bram_dout1), .busy(busy1)
    );

    // BRAM models: data appears LAT cycles after the enable cycle, junk otherwise
    logic [DW-1:0] mem0 [4];
    logic [DW-1:0] pipe0 [LAT];
    always @(posedge clk) begin
        if (bram_en && bram_we) mem0[bram_addr] <= bram_din;
        pipe0[0] <= (bram_en && !bram_we) ? mem0[bram_addr] : JUNK;
        for (int i = 1; i < LAT; i++) pipe0[i] <= pipe0[i-1];
    end
    assign bram_dout = pipe0[LAT-1];

    logic [DW-1:0] mem1 [4];
    logic [DW-1:0] pipe1;
    always @(posedge clk) begin
        if (bram_en1 && bram_we1) mem1[bram_addr1] <= bram_din1;
        pipe1 <= (bram_en1 && !bram_we1) ? mem1[bram_addr1] : JUNK;
    end
    assign bram_dout1 = pipe1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic wg, input logic rg, input logic rv,
                           input logic [DW-1:0] rdat, input logic en, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] din, input logic bz);
        chk({tag, ".wr_gnt"},   DW'(wr_gnt),   DW'(wg));
        chk({tag, ".rd_gnt"},   DW'(rd_gnt),   DW'(rg));
        chk({tag, ".rd_valid"}, DW'(rd_valid), DW'(rv));
        chk({tag, ".rd_data"},  rd_data,       rdat);
        chk({tag, ".bram_en"},  DW'(bram_en),  DW'(en));
        chk({tag, ".bram_we"},  DW'(bram_we),  DW'(we));
        chk({tag, ".busy"},     DW'(busy),     DW'(bz));
        if (en || !bz) chk({tag, ".bram_addr"}, DW'(bram_addr), DW'(a));
        if (we || !bz) chk({tag, ".bram_din"},  bram_din, din);
    endtask

    typedef struct {
        logic          wr_req;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          rd_req;
        logic [AW-1:0] rd_addr;
        logic          wg, rg, rv;
        logic [DW-1:0] rdat;
        logic          en, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          bz;
    } vec_t;

    vec_t vt [NV];

    function automatic vec_t mk(input int unsigned wr, input int unsigned wa, input logic [DW-1:0] wd,
                                input int unsigned rd, input int unsigned ra,
                                input int unsigned wg, input int unsigned rg, input int unsigned rv,
                                input logic [DW-1:0] rdat, input int unsigned en, input int unsigned we,
                                input int unsigned a, input logic [DW-1:0] din, input int unsigned bz);
        vec_t v;
        v.wr_req = 1'(wr); v.wr_addr = AW'(wa); v.wr_data = wd;
        v.rd_req = 1'(rd); v.rd_addr = AW'(ra);
        v.wg = 1'(wg); v.rg = 1'(rg); v.rv = 1'(rv); v.rdat = rdat;
        v.en = 1'(en); v.we = 1'(we); v.addr = AW'(a); v.din = din; v.bz = 1'(bz);
        return v;
    endfunction

    // reference model state for the randomized phase
    int            exp_wg_cyc, exp_rg_cyc, exp_rv_cyc, free_at;
    logic [AW-1:0] exp_wa, exp_ra;
    logic [DW-1:0] exp_wd, exp_rv_data, exp_rd_data;
    logic [DW-1:0] shadow [4];
    logic          last_rd;
    logic          win_wr;

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish, limit 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        //     wr wa wd  rd ra  wg rg rv rdat en we a din bz
        vt[0]  = mk(1, 2, D0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0);
        vt[1]  = mk(0, 0, 0,  0, 0, 1, 0, 0, 0,  1, 1, 2, D0, 1);
        vt[2]  = mk(0, 0, 0,  1, 2, 0, 0, 0, 0,  0, 0, 0, 0,  0);
        vt[3]  = mk(0, 0, 0,  0, 0, 0, 1, 0, 0,  1, 0, 2, 0,  1);
        vt[4]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1);
        vt[5]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1);
        vt[6]  = mk(1, 0, D1, 1, 2, 0, 0, 1, D0, 0, 0, 0, 0,  0);
        vt[7]  = mk(1, 3, D2, 1, 2, 1, 0, 0, D0, 1, 1, 0, D1, 1);
        vt[8]  = mk(1, 3, D2, 1, 2, 0, 0, 0, D0, 0, 0, 0, 0,  0);
        vt[9]  = mk(1, 3, D2, 1, 3, 0, 1, 0, D0, 1, 0, 2, 0,  1);
        vt[10] = mk(1, 3, D2, 1, 3, 0, 0, 0, D0, 0, 0, 0, 0,  1);
        vt[11] = mk(1, 3, D2, 1, 3, 0, 0, 0, D0, 0, 0, 0, 0,  1);
        vt[12] = mk(1, 3, D2, 1, 3, 0, 0, 1, D0, 0, 0, 0, 0,  0);
        vt[13] = mk(0, 0, 0,  1, 3, 1, 0, 0, D0, 1, 1, 3, D2, 1);
        vt[14] = mk(0, 0, 0,  1, 3, 0, 0, 0, D0, 0, 0, 0, 0,  0);
        vt[15] = mk(0, 0, 0,  0, 0, 0, 1, 0, D0, 1, 0, 3, 0,  1);
        vt[16] = mk(0, 0, 0,  0, 0, 0, 0, 0, D0, 0, 0, 0, 0,  1);
        vt[17] = mk(0, 0, 0,  0, 0, 0, 0, 0, D0, 0, 0, 0, 0,  1);
        vt[18] = mk(1, 1, D3, 1, 1, 0, 0, 1, D2, 0, 0, 0, 0,  0);
        vt[19] = mk(0, 0, 0,  1, 1, 1, 0, 0, D2, 1, 1, 1, D3, 1);
        vt[20] = mk(0, 0, 0,  1, 1, 0, 0, 0, D2, 0, 0, 0, 0,  0);
        vt[21] = mk(0, 0, 0,  0, 0, 0, 1, 0, D2, 1, 0, 1, 0,  1);
        vt[22] = mk(0, 0, 0,  0, 0, 0, 0, 0, D2, 0, 0, 0, 0,  1);
        vt[23] = mk(0, 0, 0,  0, 0, 0, 0, 0, D2, 0, 0, 0, 0,  1);
        vt[24] = mk(0, 0, 0,  0, 0, 0, 0, 1, D3, 0, 0, 0, 0,  0);
        vt[25] = mk(0, 0, 0,  0, 0, 0, 0, 0, D3, 0, 0, 0, 0,  0);

        rst = 1'b1;
        wr_req = 0; wr_addr = '0; wr_data = '0; rd_req = 0; rd_addr = '0;
        wr_req1 = 0; wr_addr1 = '0; wr_data1 = '0; rd_req1 = 0; rd_addr1 = '0;

        repeat (2) @(negedge clk);
        chk_out("reset", 0, 0, 0, '0, 0, 0, '0, '0, 0);
        chk("reset.dut1_busy", DW'(busy1), '0);
        rst = 1'b0;

        // directed table: write, read, contention alternation, read-after-write
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vt[i].wg, vt[i].rg, vt[i].rv, vt[i].rdat,
                    vt[i].en, vt[i].we, vt[i].addr, vt[i].din, vt[i].bz);
            wr_req = vt[i].wr_req; wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data;
            rd_req = vt[i].rd_req; rd_addr = vt[i].rd_addr;
        end

        // reset while a read waits on BRAM latency
        @(negedge clk); rd_req = 1; rd_addr = 2;
        @(negedge clk); chk("rstrd.gnt", DW'(rd_gnt), 1); rd_req = 0;
        @(negedge clk); chk("rstrd.wait_busy", DW'(busy), 1); rst = 1'b1;
        @(negedge clk);
        chk_out("rstrd.after", 0, 0, 0, '0, 0, 0, '0, '0, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstrd.no_valid%0d", k), DW'(rd_valid), 0);
            chk($sformatf("rstrd.idle%0d", k), DW'(busy), 0);
        end
        rd_req = 1; rd_addr = 3;
        @(negedge clk);
        chk("rstrd.new_gnt", DW'(rd_gnt), 1);
        chk("rstrd.new_addr", DW'(bram_addr), 3);
        rd_req = 0;
        @(negedge clk); chk("rstrd.new_v0", DW'(rd_valid), 0);
        @(negedge clk); chk("rstrd.new_v1", DW'(rd_valid), 0);
        @(negedge clk);
        chk("rstrd.new_valid", DW'(rd_valid), 1);
        chk("rstrd.new_data", rd_data, D2);

        // RD_LAT = 1 instance: valid two cycles after grant, never a wait cycle
        @(negedge clk); wr_req1 = 1; wr_addr1 = 0; wr_data1 = 32'hcafef00d;
        @(negedge clk); chk("lat1.wr_gnt", DW'(wr_gnt1), 1); wr_req1 = 0;
        @(negedge clk); chk("lat1.idle", DW'(busy1), 0); rd_req1 = 1; rd_addr1 = 0;
        @(negedge clk); chk("lat1.rd_gnt", DW'(rd_gnt1), 1); rd_req1 = 0;
        @(negedge clk);
        chk("lat1.done_busy", DW'(busy1), 1);
        chk("lat1.done_valid", DW'(rd_valid1), 0);
        @(negedge clk);
        chk("lat1.valid", DW'(rd_valid1), 1);
        chk("lat1.data", rd_data1, 32'hcafef00d);
        chk("lat1.back_idle", DW'(busy1), 0);

        // randomized traffic against a transaction-level model
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        shadow[0] = D1; shadow[1] = D3; shadow[2] = D0; shadow[3] = D2;
        last_rd = 1'b1;
        exp_rd_data = '0;
        exp_wg_cyc = -10; exp_rg_cyc = -10; exp_rv_cyc = -10; free_at = 0;
        exp_wa = '0; exp_ra = '0; exp_wd = '0; exp_rv_data = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == exp_rv_cyc) exp_rd_data = exp_rv_data;
            chk_out("rand", c == exp_wg_cyc, c == exp_rg_cyc, c == exp_rv_cyc, exp_rd_data,
                    (c == exp_wg_cyc) || (c == exp_rg_cyc), c == exp_wg_cyc,
                    (c == exp_wg_cyc) ? exp_wa : ((c == exp_rg_cyc) ? exp_ra : '0),
                    (c == exp_wg_cyc) ? exp_wd : '0, c < free_at);

            if (c == exp_wg_cyc) wr_req = 0;
            if (c == exp_rg_cyc) rd_req = 0;
            if (!wr_req && $urandom_range(0, 2) == 0) begin
                wr_req = 1; wr_addr = AW'($urandom); wr_data = $urandom;
            end
            if (!rd_req && $urandom_range(0, 2) == 0) begin
                rd_req = 1; rd_addr = AW'($urandom);
            end

            // an idle arbiter grants at the next cycle; write holds it 1 cycle,
            // a read holds it LAT+1 cycles and returns data LAT+2 after sampling
            if (c >= free_at && (wr_req || rd_req)) begin
                win_wr = wr_req && (!rd_req || last_rd);
                if (win_wr) begin
                    exp_wg_cyc = c + 1;
                    exp_wa = wr_addr; exp_wd = wr_data;
                    shadow[wr_addr] = wr_data;
                    free_at = c + 2;
                    last_rd = 1'b0;
                end else begin
                    exp_rg_cyc = c + 1;
                    exp_ra = rd_addr;
                    exp_rv_cyc = c + LAT + 2;
                    exp_rv_data = shadow[rd_addr];
                    free_at = c + LAT + 2;
                    last_rd = 1'b1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
